// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory arbiter: FSM state encoding and
// the round-robin search used by rr_arbiter.
package mem_arb_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } arb_state_e;

    // Widest request vector the round-robin search accepts.
    localparam int RR_MAX_REQ = 32;
    localparam int RR_IDX_W   = 5;

    // First set bit of req searching upward from last+1, wrapping at num.
    // Returns -1 when no request is set.
    function automatic int rr_next(input logic [RR_MAX_REQ-1:0] req,
                                   input int num, input int last);
        int pick;
        int idx;
        pick = -1;
        for (int k = 1; k <= RR_MAX_REQ; k++) begin
            if (k <= num) begin
                idx = (last + k) % num;
                if (pick < 0 && req[idx[RR_IDX_W-1:0]]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from the request vector,
// with the rotating priority pointer advanced only when a grant is taken.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               accept,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] last_q;
    int               pick;

    // Pick the first requester after the last one granted.
    always_comb begin
        pick  = rr_next(RR_MAX_REQ'(req), NUM_REQ, int'(last_q));
        grant = '0;
        if (pick >= 0) begin
            grant = NUM_REQ'(1) << pick;
        end
    end

    // Reset leaves the pointer on the last index so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= PTR_W'(NUM_REQ - 1);
        end else if (accept) begin
            last_q <= PTR_W'(pick);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between
// NUM_REQ requesters. Commands are registered onto mem_* one cycle after
// acceptance; read data returns to the issuing requester one cycle later.
// Optional feature macro MEM_ARB_INIT_EN: after reset, sweep every address
// with INIT_VALUE before accepting commands.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                    NUM_REQ    = 2,
    parameter int                    ADDR_WIDTH = 3,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          init_done,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic                          mem_wr_en,
    output logic                          mem_rd_en,
    output logic [DATA_WIDTH-1:0]         mem_wr_data,
    input  logic [DATA_WIDTH-1:0]         mem_rd_data
);

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_cmd_t;

    logic               arb_en;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] grant;
    logic               accept;
    req_cmd_t           cmd_p0;
    logic [NUM_REQ-1:0] rd_owner_p1;

`ifdef MEM_ARB_INIT_EN
    arb_state_e          state;
    logic [ADDR_WIDTH:0] init_cnt;
    logic                init_wr;

    // The extra counter bit marks that every address has been written.
    assign init_wr = (state == ST_INIT) && !init_cnt[ADDR_WIDTH];
    assign arb_en  = (state == ST_RUN);

    // Init sweep FSM: one write per cycle, RUN the cycle after the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
        end else if (state == ST_INIT) begin
            if (init_cnt[ADDR_WIDTH]) begin
                state     <= ST_RUN;
                init_done <= 1'b1;
            end else begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end
`else
    assign arb_en    = 1'b1;
    assign init_done = 1'b1;
`endif

    assign arb_req = req_valid & {NUM_REQ{arb_en}};

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr (
        .clk   (clk),
        .rst   (rst),
        .req   (arb_req),
        .accept(accept),
        .grant (grant)
    );

    // A grant is only ever raised on a valid requester, so it is the accept.
    assign req_ready = grant;
    assign accept    = |grant;

    // Select the granted requester's command fields.
    always_comb begin
        cmd_p0 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                cmd_p0.we    = req_we[i];
                cmd_p0.addr  = ADDR_WIDTH'(req_addr >> (i * ADDR_WIDTH));
                cmd_p0.wdata = DATA_WIDTH'(req_wdata >> (i * DATA_WIDTH));
            end
        end
    end

    // ---- stage p0 -> p1: register the command onto the memory port ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wr_en   <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
        end
`ifdef MEM_ARB_INIT_EN
        else if (init_wr) begin
            mem_wr_en   <= 1'b1;
            mem_rd_en   <= 1'b0;
            mem_addr    <= init_cnt[ADDR_WIDTH-1:0];
            mem_wr_data <= INIT_VALUE;
        end
`endif
        else if (accept) begin
            mem_wr_en   <= cmd_p0.we;
            mem_rd_en   <= ~cmd_p0.we;
            mem_addr    <= cmd_p0.addr;
            mem_wr_data <= cmd_p0.wdata;
        end else begin
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
        end
    end

    // ---- stage p1 -> p2: carry the read owner to meet the memory data ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_owner_p1 <= '0;
            rsp_valid   <= '0;
        end else begin
            rd_owner_p1 <= (accept && !cmd_p0.we) ? grant : '0;
            rsp_valid   <= rd_owner_p1;
        end
    end

    // The memory returns data in the same cycle the response is flagged.
    assign rsp_rdata = mem_rd_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// corner sequences and randomized traffic against a transaction-level model.
module tb_mem_arbiter;

    localparam int NR    = 2;
    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   req_we;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]   rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            init_done;
    logic [AW-1:0]   mem_addr;
    logic            mem_wr_en;
    logic            mem_rd_en;
    logic [DW-1:0]   mem_wr_data;
    logic [DW-1:0]   mem_rd_data;

    always #5 clk = ~clk;

    mem_arbiter #(
        .NUM_REQ   (NR),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .init_done  (init_done),
        .mem_addr   (mem_addr),
        .mem_wr_en  (mem_wr_en),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    int total = 0;
    int bad   = 0;

    // Physical memory attached to the DUT, and the model's view of contents.
    logic [DW-1:0] tb_mem  [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    typedef struct {
        int            due;
        int            owner;
        logic [DW-1:0] data;
    } rsp_t;
    rsp_t rsp_q[$];

    int m_last = NR - 1;
    int edge_n = 0;

    typedef struct {
        logic [1:0] v;
        logic [1:0] we;
        logic [2:0] a0;
        logic [2:0] a1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] exp;
    } vec_t;
    vec_t tbl[15];

    // Synchronous single-port memory with one-cycle registered read.
    initial begin
        for (int i = 0; i < DEPTH; i++) tb_mem[i] = DW'(i * 17 + 3);
        mem_rd_data = '0;
        forever begin
            @(posedge clk);
            if (mem_wr_en === 1'b1) tb_mem[mem_addr] = mem_wr_data;
            if (mem_rd_en === 1'b1) mem_rd_data <= tb_mem[mem_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of traffic: predict grant from the round-robin rule, update
    // the model's memory/response list, then check what the DUT shows.
    task automatic cycle(output int gi);
        logic          cwe;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        logic [NR-1:0] exp_g;
        logic [NR-1:0] exp_rv;
        int            idx;
        #1;
        gi = -1;
        exp_g = '0;
        cwe = 1'b0;
        ca = '0;
        cd = '0;
        for (int k = 1; k <= NR; k++) begin
            idx = (m_last + k) % NR;
            if (gi < 0 && req_valid[idx]) gi = idx;
        end
        if (gi >= 0) begin
            exp_g = NR'(1) << gi;
            cwe   = req_we[gi];
            ca    = AW'(req_addr >> (gi * AW));
            cd    = DW'(req_wdata >> (gi * DW));
            m_last = gi;
            if (cwe) ref_mem[ca] = cd;
            else rsp_q.push_back('{edge_n + 2, gi, ref_mem[ca]});
        end
        check("ready", req_ready, exp_g);
        @(posedge clk);
        #1;
        edge_n++;
        check("wr_en", mem_wr_en, (gi >= 0) && cwe);
        check("rd_en", mem_rd_en, (gi >= 0) && !cwe);
        check("wr_rd_excl", mem_wr_en & mem_rd_en, 0);
        if (gi >= 0) check("mem_addr", mem_addr, ca);
        if (gi >= 0 && cwe) check("mem_wdata", mem_wr_data, cd);
        exp_rv = '0;
        if (rsp_q.size() > 0 && rsp_q[0].due == edge_n) begin
            exp_rv = NR'(1) << rsp_q[0].owner;
            check("rsp_rdata", rsp_rdata, rsp_q[0].data);
            void'(rsp_q.pop_front());
        end
        check("rsp_valid", rsp_valid, exp_rv);
        check("init_done", init_done, 1);
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst = 1'b1;
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wr_data, 0);
`ifdef MEM_ARB_INIT_EN
        check("rst_init_done", init_done, 0);
`else
        check("rst_init_done", init_done, 1);
`endif
        @(posedge clk);
        #1;
        check("rst_hold_rsp", rsp_valid, 0);
        rst = 1'b0;
        rsp_q.delete();
        m_last = NR - 1;
`ifdef MEM_ARB_INIT_EN
        req_valid = '1;
        req_we    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            check("init_ready_low", req_ready, 0);
            check("init_done_low", init_done, 0);
            @(posedge clk);
            #1;
            check("init_wr_en", mem_wr_en, 1);
            check("init_rd_en", mem_rd_en, 0);
            check("init_addr", mem_addr, i);
            check("init_wdata", mem_wr_data, 8'hFF);
        end
        check("init_done_last", init_done, 0);
        @(posedge clk);
        #1;
        check("init_done_high", init_done, 1);
        check("init_wr_off", mem_wr_en, 0);
        req_valid = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'hFF;
`endif
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [2:0] a0, input logic [2:0] a1,
                         input logic [7:0] d0, input logic [7:0] d1);
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
    endtask

    initial begin
        int gi;
        rst = 1'b0;
        req_valid = '0;
        req_we = '0;
        req_addr = '0;
        req_wdata = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = DW'(i * 17 + 3);
        #2;
        do_reset();

        // v, we, a0, a1, d0, d1, expected ready
        tbl[0]  = '{2'b01, 2'b01, 3'd6, 3'd0, 8'h5A, 8'h00, 2'b01};
        tbl[1]  = '{2'b01, 2'b00, 3'd6, 3'd0, 8'h00, 8'h00, 2'b01};
        tbl[2]  = '{2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00};
        tbl[3]  = '{2'b11, 2'b00, 3'd1, 3'd2, 8'h00, 8'h00, 2'b10};
        tbl[4]  = '{2'b11, 2'b00, 3'd1, 3'd2, 8'h00, 8'h00, 2'b01};
        tbl[5]  = '{2'b11, 2'b00, 3'd3, 3'd6, 8'h00, 8'h00, 2'b10};
        tbl[6]  = '{2'b11, 2'b00, 3'd7, 3'd6, 8'h00, 8'h00, 2'b01};
        tbl[7]  = '{2'b10, 2'b10, 3'd0, 3'd4, 8'h00, 8'hC3, 2'b10};
        tbl[8]  = '{2'b11, 2'b00, 3'd4, 3'd0, 8'h00, 8'h00, 2'b01};
        tbl[9]  = '{2'b11, 2'b00, 3'd4, 3'd0, 8'h00, 8'h00, 2'b10};
        tbl[10] = '{2'b01, 2'b00, 3'd2, 3'd0, 8'h00, 8'h00, 2'b01};
        tbl[11] = '{2'b11, 2'b01, 3'd1, 3'd5, 8'h77, 8'h00, 2'b10};
        tbl[12] = '{2'b10, 2'b00, 3'd1, 3'd4, 8'h00, 8'h00, 2'b10};
        tbl[13] = '{2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00};
        tbl[14] = '{2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00};

        for (int r = 0; r < 15; r++) begin
            drive(tbl[r].v, tbl[r].we, tbl[r].a0, tbl[r].a1, tbl[r].d0, tbl[r].d1);
            #1;
            check("tbl_ready", req_ready, tbl[r].exp);
            cycle(gi);
        end

        // Write then read by the same requester: response two cycles later.
        drive(2'b01, 2'b01, 3'd3, 3'd0, 8'hA5, 8'h00);
        cycle(gi);
        drive(2'b01, 2'b00, 3'd3, 3'd0, 8'h00, 8'h00);
        cycle(gi);
        drive(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);
        cycle(gi);
        check("a5_rsp_valid", rsp_valid, 2'b01);
        check("a5_rsp_rdata", rsp_rdata, 8'hA5);

        // Write by req0 followed next cycle by a read of the same address by req1.
        drive(2'b01, 2'b01, 3'd5, 3'd0, 8'h3C, 8'h00);
        cycle(gi);
        drive(2'b10, 2'b00, 3'd0, 3'd5, 8'h00, 8'h00);
        cycle(gi);
        drive(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);
        cycle(gi);
        check("3c_rsp_valid", rsp_valid, 2'b10);
        check("3c_rsp_rdata", rsp_rdata, 8'h3C);

        // Reset with reads in flight: nothing may come back afterwards.
        drive(2'b11, 2'b00, 3'd1, 3'd2, 8'h00, 8'h00);
        cycle(gi);
        cycle(gi);
        do_reset();
        for (int i = 0; i < 3; i++) cycle(gi);

        // Randomized traffic honouring the hold-until-accepted rule.
        gi = -1;
        for (int n = 0; n < 600; n++) begin
            if (n == 300) begin
                do_reset();
                gi = -1;
            end
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && gi != i) begin
                    if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    req_we[i]    = ($urandom_range(0, 2) == 0);
                    req_addr[i*AW +: AW]  = AW'($urandom_range(0, DEPTH - 1));
                    req_wdata[i*DW +: DW] = DW'($urandom);
                end
            end
            cycle(gi);
        end
        req_valid = '0;
        for (int i = 0; i < 3; i++) cycle(gi);
        check("rsp_drained", rsp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
